// File: rtl/instr_field_demux.sv
// instr_field_demux: steers a stream of instruction-memory words into an
// opcode register and up to MAX_OPERANDS operand registers. The operand
// count is encoded in the top LEN_W bits of the opcode. A complete
// instruction is offered to the decoder with a valid/ready handshake.
//
// Optional feature (macro INSTR_FIELD_DEMUX_PIPE_EN): while an instruction
// is being consumed, the next opcode may be accepted in the same cycle,
// allowing back-to-back zero-operand instructions at one per clock.
// Without the macro, one bubble cycle separates instructions.

module instr_field_demux #(
  parameter int DATA_W       = 8,
  parameter int MAX_OPERANDS = 2,
  parameter int LEN_W        = 2
) (
  input  logic                             instr_field_demux_clk,
  input  logic                             instr_field_demux_rst_n,
  input  logic                             instr_field_demux_flush,
  input  logic [DATA_W-1:0]                instr_field_demux_in_data,
  input  logic                             instr_field_demux_in_valid,
  output logic                             instr_field_demux_in_ready,
  output logic [DATA_W-1:0]                instr_field_demux_opcode,
  output logic [MAX_OPERANDS*DATA_W-1:0]   instr_field_demux_operands,
  output logic [$clog2(MAX_OPERANDS+1)-1:0] instr_field_demux_operand_cnt,
  output logic                             instr_field_demux_len_clamped,
  output logic                             instr_field_demux_out_valid,
  input  logic                             instr_field_demux_out_ready
);

  localparam int CNT_W = $clog2(MAX_OPERANDS + 1);
  localparam int IDX_W = (MAX_OPERANDS > 1) ? $clog2(MAX_OPERANDS) : 1;
  // Comparison width wide enough for both the encoded field and the limit.
  localparam int CMP_W = ((LEN_W > CNT_W) ? LEN_W : CNT_W) + 1;

`ifdef INSTR_FIELD_DEMUX_PIPE_EN
  localparam logic PIPE_EN = 1'b1;
`else
  localparam logic PIPE_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    FETCH_OP   = 2'd0,
    FETCH_OPND = 2'd1,
    HOLD       = 2'd2
  } state_e;

  state_e                         state_q;
  logic [IDX_W-1:0]               idx_q;
  logic [DATA_W-1:0]              opcode_q;
  logic [MAX_OPERANDS*DATA_W-1:0] operands_q;
  logic [CNT_W-1:0]               operand_cnt_q;
  logic                           len_clamped_q;
  logic                           out_valid_q;

  logic [LEN_W-1:0] n_enc_s;
  logic             clamp_s;
  logic [CNT_W-1:0] n_s;
  logic             in_ready_s;
  logic             xfer_s;
  logic             capture_s;
  logic             last_opnd_s;

  // Decode the operand count carried by the incoming word (used on capture).
  always_comb begin
    n_enc_s = instr_field_demux_in_data[DATA_W-1 -: LEN_W];
    clamp_s = (CMP_W'(n_enc_s) > CMP_W'(MAX_OPERANDS));
    if (clamp_s) begin
      n_s = CNT_W'(MAX_OPERANDS);
    end else begin
      n_s = CNT_W'(n_enc_s);
    end
  end

  // Input acceptance depends only on state and flush (plus out_ready when pipelined).
  always_comb begin
    in_ready_s = 1'b0;
    case (state_q)
      FETCH_OP:   in_ready_s = !instr_field_demux_flush;
      FETCH_OPND: in_ready_s = !instr_field_demux_flush;
      HOLD:       in_ready_s = PIPE_EN && instr_field_demux_out_ready && !instr_field_demux_flush;
      default:    in_ready_s = 1'b0;
    endcase
  end

  // Transfer qualifiers: a word moves, and whether it lands as a new opcode.
  always_comb begin
    xfer_s      = instr_field_demux_in_valid && in_ready_s;
    capture_s   = xfer_s && ((state_q == FETCH_OP) || (state_q == HOLD));
    last_opnd_s = ((CNT_W'(idx_q) + CNT_W'(1'b1)) == operand_cnt_q);
  end

  // Field-steering FSM with all datapath and handshake outputs registered.
  always_ff @(posedge instr_field_demux_clk or negedge instr_field_demux_rst_n) begin
    if (!instr_field_demux_rst_n) begin
      state_q       <= FETCH_OP;
      idx_q         <= '0;
      opcode_q      <= '0;
      operands_q    <= '0;
      operand_cnt_q <= '0;
      len_clamped_q <= 1'b0;
      out_valid_q   <= 1'b0;
    end else if (instr_field_demux_flush) begin
      // Abort the instruction in flight; field registers are left as-is and
      // get cleared on the next opcode capture.
      state_q     <= FETCH_OP;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
    end else if (capture_s) begin
      opcode_q      <= instr_field_demux_in_data;
      operands_q    <= '0;
      operand_cnt_q <= n_s;
      len_clamped_q <= clamp_s;
      idx_q         <= '0;
      if (n_s == '0) begin
        state_q     <= HOLD;
        out_valid_q <= 1'b1;
      end else begin
        state_q     <= FETCH_OPND;
        out_valid_q <= 1'b0;
      end
    end else begin
      case (state_q)
        FETCH_OP: begin
          state_q <= FETCH_OP;
        end
        FETCH_OPND: begin
          if (xfer_s) begin
            for (int k = 0; k < MAX_OPERANDS; k++) begin
              if (idx_q == IDX_W'(k)) begin
                operands_q[k*DATA_W +: DATA_W] <= instr_field_demux_in_data;
              end
            end
            if (last_opnd_s) begin
              state_q     <= HOLD;
              out_valid_q <= 1'b1;
            end else begin
              idx_q <= idx_q + IDX_W'(1'b1);
            end
          end
        end
        HOLD: begin
          if (instr_field_demux_out_ready) begin
            state_q     <= FETCH_OP;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= FETCH_OP;
          idx_q       <= '0;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign instr_field_demux_in_ready    = in_ready_s;
  assign instr_field_demux_opcode      = opcode_q;
  assign instr_field_demux_operands    = operands_q;
  assign instr_field_demux_operand_cnt = operand_cnt_q;
  assign instr_field_demux_len_clamped = len_clamped_q;
  assign instr_field_demux_out_valid   = out_valid_q;

endmodule

// File: tb/tb_instr_field_demux.sv
// Directed self-checking bench for instr_field_demux (DATA_W=8, MAX_OPERANDS=2).
// Define INSTR_FIELD_DEMUX_PIPE_EN for both bench and RTL to check the
// pipelined handoff spacing.

module tb_instr_field_demux;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  opcode;
  logic [15:0] operands;
  logic [1:0]  operand_cnt;
  logic        len_clamped;
  logic        out_valid;
  logic        out_ready;

  int n_cmp;
  int n_mis;

`ifdef INSTR_FIELD_DEMUX_PIPE_EN
  localparam int EXP_GAP = 1;
`else
  localparam int EXP_GAP = 2;
`endif

  instr_field_demux #(
    .DATA_W(8), .MAX_OPERANDS(2), .LEN_W(2)
  ) dut (
    .instr_field_demux_clk        (clk),
    .instr_field_demux_rst_n      (rst_n),
    .instr_field_demux_flush      (flush),
    .instr_field_demux_in_data    (in_data),
    .instr_field_demux_in_valid   (in_valid),
    .instr_field_demux_in_ready   (in_ready),
    .instr_field_demux_opcode     (opcode),
    .instr_field_demux_operands   (operands),
    .instr_field_demux_operand_cnt(operand_cnt),
    .instr_field_demux_len_clamped(len_clamped),
    .instr_field_demux_out_valid  (out_valid),
    .instr_field_demux_out_ready  (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present one word for one cycle; inputs change #1 after the edge.
  task automatic send_word(input logic [7:0] d);
    in_data  = d;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic check_instr(input string tag, input logic [7:0] op, input logic [15:0] opnds,
                             input logic [1:0] cnt, input logic lc);
    chk_eq({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk_eq({tag, "_opcode"}, {24'd0, opcode}, {24'd0, op});
    chk_eq({tag, "_operands"}, {16'd0, operands}, {16'd0, opnds});
    chk_eq({tag, "_cnt"}, {30'd0, operand_cnt}, {30'd0, cnt});
    chk_eq({tag, "_clamped"}, {31'd0, len_clamped}, {31'd0, lc});
  endtask

  initial begin
    logic [7:0] words [3];
    int wi;
    int seen;
    int last_cyc;
    logic xfer;

    n_cmp = 0; n_mis = 0;
    rst_n = 1'b0; flush = 1'b0; in_data = 8'h00; in_valid = 1'b0; out_ready = 1'b0;

    // 1. reset state and a zero-operand instruction
    repeat (3) @(posedge clk);
    #1;
    chk_eq("rst_opcode", {24'd0, opcode}, 32'd0);
    chk_eq("rst_operands", {16'd0, operands}, 32'd0);
    chk_eq("rst_cnt", {30'd0, operand_cnt}, 32'd0);
    chk_eq("rst_clamped", {31'd0, len_clamped}, 32'd0);
    chk_eq("rst_valid", {31'd0, out_valid}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk_eq("rst_in_ready", {31'd0, in_ready}, 32'd1);
    send_word(8'h05);
    check_instr("t1", 8'h05, 16'h0000, 2'd0, 1'b0);
    consume();
    chk_eq("t1_valid_drop", {31'd0, out_valid}, 32'd0);

    // 2. two operands, held under backpressure
    send_word(8'h8C);
    chk_eq("t2_mid_valid", {31'd0, out_valid}, 32'd0);
    send_word(8'h12);
    send_word(8'h34);
    check_instr("t2", 8'h8C, 16'h3412, 2'd2, 1'b0);
    chk_eq("t2_in_ready_hold", {31'd0, in_ready}, 32'd0);
    in_data = 8'hEE; in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check_instr("t2_held", 8'h8C, 16'h3412, 2'd2, 1'b0);
    end
    in_valid = 1'b0;
    consume();
    chk_eq("t2_valid_drop", {31'd0, out_valid}, 32'd0);
    chk_eq("t2_in_ready_back", {31'd0, in_ready}, 32'd1);

    // 3. clamped count; trailing words form the next instruction
    send_word(8'hC1);
    send_word(8'hAA);
    send_word(8'hBB);
    check_instr("t3a", 8'hC1, 16'hBBAA, 2'd2, 1'b1);
    consume();
    send_word(8'h4A);
    send_word(8'h77);
    check_instr("t3b", 8'h4A, 16'h0077, 2'd1, 1'b0);
    consume();

    // 4. flush mid-instruction
    send_word(8'h8C);
    send_word(8'h12);
    flush = 1'b1; in_data = 8'h99; in_valid = 1'b1;
    #1;
    chk_eq("t4_in_ready_flush", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    chk_eq("t4_valid", {31'd0, out_valid}, 32'd0);
    chk_eq("t4_opcode_kept", {24'd0, opcode}, 32'h8C);
    @(posedge clk); #1;
    chk_eq("t4_valid_later", {31'd0, out_valid}, 32'd0);
    send_word(8'h4A);
    send_word(8'h55);
    check_instr("t4", 8'h4A, 16'h0055, 2'd1, 1'b0);
    consume();

    // 5. asynchronous reset mid-instruction
    send_word(8'h8C);
    send_word(8'h12);
    #2;
    rst_n = 1'b0;
    #1;
    chk_eq("t5_opcode", {24'd0, opcode}, 32'd0);
    chk_eq("t5_operands", {16'd0, operands}, 32'd0);
    chk_eq("t5_cnt", {30'd0, operand_cnt}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    send_word(8'h05);
    check_instr("t5", 8'h05, 16'h0000, 2'd0, 1'b0);
    consume();

    // 6. back-to-back zero-operand instructions with out_ready held high
    words[0] = 8'h01; words[1] = 8'h02; words[2] = 8'h03;
    wi = 0; seen = 0; last_cyc = 0;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 12; cyc++) begin
      in_valid = (wi < 3);
      in_data  = (wi < 3) ? words[wi] : 8'h00;
      #1;
      xfer = in_valid && in_ready;
      @(posedge clk); #1;
      if (xfer) wi++;
      if (out_valid) begin
        if (seen < 3) begin
          chk_eq("t6_opcode", {24'd0, opcode}, {24'd0, words[seen]});
          if (seen > 0) chk_eq("t6_gap", cyc - last_cyc, EXP_GAP);
        end
        last_cyc = cyc;
        seen++;
      end
    end
    in_valid = 1'b0; out_ready = 1'b0;
    chk_eq("t6_count", seen, 32'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
